// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: advances, holds or redirects the PC
// around control-transfer instructions and downstream stalls.
module fetch_sequencer #(
    parameter int          PC_W     = 7,
    parameter logic [5:0]  OPC_BEQ  = 6'b000100,
    parameter logic [5:0]  OPC_BNE  = 6'b000101,
    parameter logic [5:0]  OPC_J    = 6'b000010,
    parameter int          MAX_WAIT = 8,
    parameter int          CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic            stall_req,
    input  logic            br_resolved,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            pc_enable,
    output logic            pc_sel,
    output logic [PC_W-1:0] pc_target,
    output logic            bubble,
    output logic            flush,
    output logic            timeout_err,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc_target;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic               w_is_br;
    logic               w_bubble;
    logic               w_count_bubble;

    assign w_is_br = (opcode == OPC_BEQ) || (opcode == OPC_BNE) ||
                     (opcode == OPC_J);

    // Output decode: state only, pc_enable additionally gated by stall
    always_comb begin
        pc_enable = 1'b0;
        pc_sel    = 1'b0;
        w_bubble  = 1'b1;
        flush     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_bubble = 1'b1;
            end
            RUN: begin
                pc_enable = !stall_req;
                w_bubble  = 1'b0;
            end
            WAIT: begin
                w_bubble = 1'b1;
            end
            REDIRECT: begin
                pc_enable = !stall_req;
                pc_sel    = 1'b1;
                flush     = 1'b1;
            end
            default: begin
                w_bubble = 1'b1;
            end
        endcase
    end

    assign w_count_bubble = w_bubble && (r_state != IDLE) &&
                            (r_bubble_cnt != '1);

    // State transitions, redirect target, wait timer and debug stats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pc_target   <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_bubble_cnt  <= '0;
        end else begin
            if (w_count_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_state <= RUN;
                end
                RUN: begin
                    // a stalled branch is re-sampled next cycle
                    if (w_is_br && !stall_req) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (br_resolved && br_taken) begin
                        r_pc_target <= br_target;
                        r_state     <= REDIRECT;
                    end else if (br_resolved) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= RUN;
                    end
                end
                REDIRECT: begin
                    if (!stall_req) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bubble      = w_bubble;
    assign pc_target   = r_pc_target;
    assign timeout_err = r_timeout_err;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table
// plus a bubble-counter saturation sequence.
module tb_fetch_sequencer;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic       stall_req = 1'b0;
    logic       br_resolved = 1'b0;
    logic       br_taken = 1'b0;
    logic [6:0] br_target = '0;
    logic       pc_enable;
    logic       pc_sel;
    logic [6:0] pc_target;
    logic       bubble;
    logic       flush;
    logic       timeout_err;
    logic [7:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic       st;
        logic       rv;
        logic       tk;
        logic [6:0] tg;
        logic       en;
        logic       sel;
        logic       bub;
        logic       fl;
        logic [6:0] tgt;
        logic       to;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .stall_req  (stall_req),
        .br_resolved(br_resolved),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc_enable  (pc_enable),
        .pc_sel     (pc_sel),
        .pc_target  (pc_target),
        .bubble     (bubble),
        .flush      (flush),
        .timeout_err(timeout_err),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] op,
                       input logic st, input logic rv, input logic tk,
                       input logic [6:0] tg, input logic en,
                       input logic sel, input logic bub, input logic fl,
                       input logic [6:0] tgt, input logic to,
                       input logic [7:0] cnt);
        vec_t v;
        v.r = r; v.op = op; v.st = st; v.rv = rv; v.tk = tk; v.tg = tg;
        v.en = en; v.sel = sel; v.bub = bub; v.fl = fl;
        v.tgt = tgt; v.to = to; v.cnt = cnt;
        vq.push_back(v);
    endtask

    // RUN-state row with no stall and no resolve
    task automatic run_row(input logic [5:0] op, input logic [6:0] tgt,
                           input logic to, input logic [7:0] cnt);
        add(1, op, 0, 0, 0, 0, 1, 0, 0, 0, tgt, to, cnt);
    endtask

    // WAIT-state row with no resolve
    task automatic wait_row(input logic [6:0] tgt, input logic to,
                            input logic [7:0] cnt);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, tgt, to, cnt);
    endtask

    task automatic branch_timeout(input string tag);
        int n;
        @(negedge clk);
        opcode = BEQ;
        @(negedge clk);
        opcode = '0;
        for (n = 0; n < 16; n++) begin
            #1;
            if (pc_enable) break;
            @(negedge clk);
        end
        chk({tag, ".wait_len"}, n, 8);
    endtask

    initial begin
        // reset and IDLE
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        run_row(0, 0, 0, 0);
        // taken branch resolved on the third WAIT cycle
        run_row(BEQ, 0, 0, 0);
        wait_row(0, 0, 0);
        wait_row(0, 0, 1);
        add(1, 0, 0, 1, 1, 7'h2A, 0, 0, 1, 0, 7'h00, 0, 2);
        add(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 7'h2A, 0, 3);
        run_row(0, 7'h2A, 0, 4);
        // not-taken branch
        run_row(BNE, 7'h2A, 0, 4);
        wait_row(7'h2A, 0, 4);
        wait_row(7'h2A, 0, 5);
        add(1, 0, 0, 1, 0, 7'h55, 0, 0, 1, 0, 7'h2A, 0, 6);
        run_row(0, 7'h2A, 0, 7);
        // jump held off by stall, stall ignored in WAIT
        add(1, JMP, 1, 0, 0, 0, 0, 0, 0, 0, 7'h2A, 0, 7);
        add(1, JMP, 1, 0, 0, 0, 0, 0, 0, 0, 7'h2A, 0, 7);
        run_row(JMP, 7'h2A, 0, 7);
        add(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 7'h2A, 0, 7);
        add(1, 0, 0, 1, 1, 7'h13, 0, 0, 1, 0, 7'h2A, 0, 8);
        // REDIRECT stalled for 3 cycles
        add(1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 7'h13, 0, 9);
        add(1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 7'h13, 0, 10);
        add(1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 7'h13, 0, 11);
        add(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 7'h13, 0, 12);
        run_row(0, 7'h13, 0, 13);
        // spurious resolve in RUN is ignored
        add(1, 0, 0, 1, 1, 7'h7F, 1, 0, 0, 0, 7'h13, 0, 13);
        run_row(0, 7'h13, 0, 13);
        // resolve on the last WAIT cycle wins over timeout
        run_row(BEQ, 7'h13, 0, 13);
        for (int i = 0; i < 7; i++) wait_row(7'h13, 0, 8'(13 + i));
        add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 7'h13, 0, 20);
        run_row(0, 7'h13, 0, 21);
        // real timeout after 8 WAIT cycles
        run_row(BEQ, 7'h13, 0, 21);
        for (int i = 0; i < 8; i++) wait_row(7'h13, 0, 8'(21 + i));
        run_row(BEQ, 7'h13, 1, 29);
        wait_row(7'h13, 1, 29);
        // reset during WAIT
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        run_row(0, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst         = vq[i].r;
            opcode      = vq[i].op;
            stall_req   = vq[i].st;
            br_resolved = vq[i].rv;
            br_taken    = vq[i].tk;
            br_target   = vq[i].tg;
            #1;
            chk($sformatf("v%0d.pc_enable", i), pc_enable, vq[i].en);
            chk($sformatf("v%0d.pc_sel", i), pc_sel, vq[i].sel);
            chk($sformatf("v%0d.bubble", i), bubble, vq[i].bub);
            chk($sformatf("v%0d.flush", i), flush, vq[i].fl);
            chk($sformatf("v%0d.pc_target", i), pc_target, vq[i].tgt);
            chk($sformatf("v%0d.timeout_err", i), timeout_err, vq[i].to);
            chk($sformatf("v%0d.bubble_cnt", i), bubble_cnt, vq[i].cnt);
        end

        // bubble counter saturation: 8 bubbles per timed-out branch
        @(negedge clk);
        opcode = '0; stall_req = 0; br_resolved = 0; br_taken = 0;
        for (int k = 0; k < 31; k++) branch_timeout($sformatf("sat%0d", k));
        chk("sat.cnt248", bubble_cnt, 248);
        for (int k = 31; k < 34; k++) branch_timeout($sformatf("sat%0d", k));
        chk("sat.cnt255", bubble_cnt, 255);
        chk("sat.timeout", timeout_err, 1);
        chk("sat.run_sel", pc_sel, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
